parallel_to_serial: RTL and testbench

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

---
 rtl/serial_pkg.sv | 15 +
 rtl/parallel_to_serial.sv | 100 ++++++++++
 tb/tb_parallel_to_serial.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_pkg : shared state encoding and line levels for the serialiser
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic SERIAL_IDLE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/parallel_to_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parallel_to_serial : MSB-first word serialiser with optional idle gap
// Rev 1.0
// ---------------------------------------------------------------------------
module parallel_to_serial
  import serial_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             last_bit,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
  localparam logic [GW-1:0] c_gap_last = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_serial;
  logic             r_frame_done;

  logic w_last_bit;
  logic w_in_ready;
  logic w_accept;

  assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == c_cnt_last);
  // With no gap, the last-bit cycle doubles as an acceptance slot so words stream without a bubble.
  assign w_in_ready = (r_state == IDLE) || ((GAP_CYCLES == 0) && w_last_bit);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_serial     <= SERIAL_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_bit;
      if (w_accept) begin
        // The MSB goes straight to the output register; the rest waits in the shifter.
        r_state   <= SHIFT;
        r_serial  <= in_data[WIDTH-1];
        r_shreg   <= {in_data[WIDTH-2:0], 1'b0};
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          SHIFT: begin
            if (w_last_bit) begin
              r_serial  <= SERIAL_IDLE;
              r_shreg   <= '0;
              r_bit_cnt <= '0;
              r_gap_cnt <= '0;
              r_state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
              r_serial  <= r_shreg[WIDTH-1];
              r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end
          GAP: begin
            if (r_gap_cnt == c_gap_last) begin
              r_gap_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + GW'(1);
            end
          end
          default: begin
            r_serial <= SERIAL_IDLE;
            r_state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign serial_out = r_serial;
  assign last_bit   = w_last_bit;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_parallel_to_serial : random + directed check of two serialisers (gap 0 / gap 1)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_parallel_to_serial;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] iv;
  logic [3:0] id [2];
  logic [1:0] so, rdy, lb, fd, bsy;
  logic [3:0] dq [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-position model: -1 idle, 0..W-1 data bit index, W.. gap cycles.
  int         m_pos  [2];
  logic [3:0] m_word [2];
  logic [3:0] m_done [2];
  logic       m_fd   [2];

  always #5 clk = ~clk;

  parallel_to_serial #(.WIDTH(W), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .in_data(id[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .serial_out(so[0]), .last_bit(lb[0]), .frame_done(fd[0]), .busy(bsy[0])
  );

  parallel_to_serial #(.WIDTH(W), .GAP_CYCLES(1)) dut_g1 (
    .clk(clk), .rst(rst), .in_data(id[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .serial_out(so[1]), .last_bit(lb[1]), .frame_done(fd[1]), .busy(bsy[1])
  );

  // Downstream shift registers fed by the serial lines.
  always @(posedge clk) begin
    dq[0] <= {dq[0][2:0], so[0]};
    dq[1] <= {dq[1][2:0], so[1]};
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = -1;
      m_fd[i]  = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s serial_out g%0d", tag, gap_of(i)), 32'(so[i]), 32'd0);
      check($sformatf("%s in_ready g%0d", tag, gap_of(i)), 32'(rdy[i]), 32'd1);
      check($sformatf("%s busy g%0d", tag, gap_of(i)), 32'(bsy[i]), 32'd0);
      check($sformatf("%s frame_done g%0d", tag, gap_of(i)), 32'(fd[i]), 32'd0);
      check($sformatf("%s last_bit g%0d", tag, gap_of(i)), 32'(lb[i]), 32'd0);
    end
  endtask

  // Called at a falling edge: asserts reset between clock edges, holds it 3 cycles with valid high.
  task automatic reset_pulse();
    rst = 1'b1;
    iv = 2'b11;
    id[0] = 4'hF;
    id[1] = 4'hF;
    #1;
    check_idle("rst_async");
    model_reset();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("rst_hold");
    end
    rst = 1'b0;
    iv = 2'b00;
  endtask

  // One clock cycle for both DUTs, entered and left at a falling edge.
  task automatic step(input logic v0, input logic [3:0] d0, input logic v1, input logic [3:0] d1);
    logic acc [2];
    logic e_last, e_ser, e_rdy;
    int   p;
    iv[0] = v0; id[0] = d0;
    iv[1] = v1; id[1] = d1;
    for (int i = 0; i < 2; i++) begin
      p      = m_pos[i];
      e_last = (p == W - 1);
      e_ser  = (p >= 0 && p < W) ? m_word[i][W-1-p] : 1'b0;
      e_rdy  = (p < 0) || (gap_of(i) == 0 && e_last);
      check($sformatf("serial_out g%0d", gap_of(i)), 32'(so[i]), 32'(e_ser));
      check($sformatf("last_bit g%0d", gap_of(i)), 32'(lb[i]), 32'(e_last));
      check($sformatf("in_ready g%0d", gap_of(i)), 32'(rdy[i]), 32'(e_rdy));
      check($sformatf("busy g%0d", gap_of(i)), 32'(bsy[i]), 32'(p >= 0));
      check($sformatf("frame_done g%0d", gap_of(i)), 32'(fd[i]), 32'(m_fd[i]));
      if (m_fd[i])
        check($sformatf("downstream_q g%0d", gap_of(i)), 32'(dq[i]), 32'(m_done[i]));
      acc[i] = iv[i] && e_rdy;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      p = m_pos[i];
      m_fd[i] = (p == W - 1);
      if (m_fd[i]) m_done[i] = m_word[i];
      if (acc[i]) begin
        m_pos[i]  = 0;
        m_word[i] = id[i];
      end else if (p >= 0) begin
        m_pos[i] = (p + 1 >= W + gap_of(i)) ? -1 : p + 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    iv = 2'b00;
    id[0] = 4'h0;
    id[1] = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_idle("por");
    rst = 1'b0;

    reset_pulse();

    // Single word on gap-1, back-to-back pair on gap-0.
    step(1'b1, 4'b1100, 1'b1, 4'b1011);
    repeat (3) step(1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 4'b0110, 1'b0, 4'h0);
    repeat (6) step(1'b0, 4'h0, 1'b0, 4'h0);

    // Valid held with 1111 while 0001 is in flight; only one extra word may go in.
    step(1'b1, 4'b0001, 1'b1, 4'b0001);
    repeat (6) step(1'b1, 4'b1111, 1'b1, 4'b1111);
    repeat (8) step(1'b0, 4'h0, 1'b0, 4'h0);

    // Reset in the middle of a word, then a clean word.
    step(1'b1, 4'b1010, 1'b1, 4'b1010);
    step(1'b0, 4'h0, 1'b0, 4'h0);
    reset_pulse();
    step(1'b1, 4'b0101, 1'b1, 4'b0101);
    repeat (6) step(1'b0, 4'h0, 1'b0, 4'h0);

    // Every 4-bit value through both instances.
    for (int v = 0; v < 16; v++)
      repeat (7) step(1'b1, 4'(v), 1'b1, 4'(v));
    repeat (6) step(1'b0, 4'h0, 1'b0, 4'h0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 60) == 0)
        reset_pulse();
      else
        step($urandom_range(0, 2) != 0, 4'($urandom), $urandom_range(0, 2) != 0, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
